regfile_mp: RTL and testbench

Parametrised multi-ported register file with write-back scoreboard, the next-generation operand store for the pipelined core. Provides NRD combinational read ports and NWR clocked write ports, a configurable hardwired-zero register, and optional write-to-read bypass. A per-register pending bit tracks in-flight writes so decode can stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the address-width helper used by decode and
// the hazard unit.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight writes: read-port busy flags, the
// registered pending count and the dual-write address conflict flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic [NRD*AW-1:0] ra,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic              wr_conflict,
    output logic [AW:0]       pend_cnt
);

    logic [DEPTH-1:0] pend_q, pend_d, wr_hit;
    logic [AW:0]      cnt_d;
    logic             conflict_d;

    always_comb begin
        wr_hit = '0;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (we[p]) wr_hit[wa[p*AW +: AW]] = 1'b1;
        end
        // Issue wins over write-back so a reissued destination stays pending.
        pend_d = pend_q & ~wr_hit;
        if (iss_en) pend_d[iss_addr] = 1'b1;
        if (ZERO_REG) pend_d[0] = 1'b0;
        cnt_d = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[a]};
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_busy[i] = pend_q[ra[i*AW +: AW]] && !(BYPASS && wr_hit[ra[i*AW +: AW]]);
            if (ZERO_REG && (ra[i*AW +: AW] == '0)) rd_busy[i] = 1'b0;
        end
    end

    assign conflict_d = (NWR == 2) && we[0] && we[NWR-1] &&
                        (wa[0 +: AW] == wa[(NWR-1)*AW +: AW]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_cnt    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_cnt    <= cnt_d;
            wr_conflict <= conflict_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: NWR clocked write ports, NRD combinational read
// ports with optional write-to-read bypass, plus a write-back scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*WIDTH-1:0] wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 wr_conflict,
    output logic [AW:0]          pend_cnt
);

    logic [WIDTH-1:0] rf_q [DEPTH];

    // Later ports assign last, so the highest-index port wins on equal addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < DEPTH; a++) rf_q[a] <= '0;
        end else begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (we[p] && !(ZERO_REG && (wa[p*AW +: AW] == '0))) begin
                    rf_q[wa[p*AW +: AW]] <= wd[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Bypass is gated by rst_n: a write in a reset cycle never lands, so never forward it.
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd[i*WIDTH +: WIDTH] = rf_q[ra[i*AW +: AW]];
            for (int unsigned p = 0; p < NWR; p++) begin
                if (BYPASS && rst_n && we[p] && (wa[p*AW +: AW] == ra[i*AW +: AW])) begin
                    rd[i*WIDTH +: WIDTH] = wd[p*WIDTH +: WIDTH];
                end
            end
            if (ZERO_REG && (ra[i*AW +: AW] == '0)) rd[i*WIDTH +: WIDTH] = '0;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wa          (wa),
        .ra          (ra),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .rd_busy     (rd_busy),
        .wr_conflict (wr_conflict),
        .pend_cnt    (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a dual-write bypassing instance and a single-write non-bypassing
// instance share clock and reset.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        wr_conflict;
    logic [5:0]  pend_cnt;

    logic [0:0]  we_n;
    logic [4:0]  wa_n;
    logic [31:0] wd_n;
    logic [9:0]  ra_n;
    logic [63:0] rd_n;
    logic [1:0]  busy_n;
    logic        iss_en_n;
    logic [4:0]  iss_addr_n;
    logic        wrc_n;
    logic [5:0]  pcnt_n;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .WIDTH (32), .DEPTH (32), .NRD (2), .NWR (2), .ZERO_REG (1'b1), .BYPASS (1'b1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .we (we), .wa (wa), .wd (wd), .ra (ra), .rd (rd),
        .rd_busy (rd_busy), .iss_en (iss_en), .iss_addr (iss_addr),
        .wr_conflict (wr_conflict), .pend_cnt (pend_cnt)
    );

    regfile_mp #(
        .WIDTH (32), .DEPTH (32), .NRD (2), .NWR (1), .ZERO_REG (1'b1), .BYPASS (1'b0)
    ) dut_nb (
        .clk (clk), .rst_n (rst_n), .we (we_n), .wa (wa_n), .wd (wd_n), .ra (ra_n),
        .rd (rd_n), .rd_busy (busy_n), .iss_en (iss_en_n), .iss_addr (iss_addr_n),
        .wr_conflict (wrc_n), .pend_cnt (pcnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; iss_en = 1'b0; iss_addr = '0;
        we_n = '0; wa_n = '0; wd_n = '0; iss_en_n = 1'b0; iss_addr_n = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        ra = '0; ra_n = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            ra = {a[4:0], a[4:0]};
            ra_n = {a[4:0], a[4:0]};
            #1;
            vec_cnt++;
            if (rd !== 64'h0 || rd_busy !== 2'b00) begin
                err_cnt++;
                $display("FAIL reset_read a=%0d rd=%h busy=%b want 0/00", a, rd, rd_busy);
            end
            vec_cnt++;
            if (rd_n !== 64'h0 || busy_n !== 2'b00) begin
                err_cnt++;
                $display("FAIL reset_read_nb a=%0d rd=%h busy=%b want 0/00", a, rd_n, busy_n);
            end
        end
        vec_cnt++;
        if (pend_cnt !== 6'd0 || wr_conflict !== 1'b0 || pcnt_n !== 6'd0) begin
            err_cnt++;
            $display("FAIL reset_regs pend=%0d conf=%b pend_nb=%0d want 0", pend_cnt,
                     wr_conflict, pcnt_n);
        end
    endtask

    task automatic test_write_read();
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        ra = {5'd0, 5'd5};
        #1;
        vec_cnt++;
        if (rd[31:0] !== 32'hDEADBEEF) begin
            err_cnt++;
            $display("FAIL write_r5 got %h want deadbeef", rd[31:0]);
        end
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'h1234};
        ra = {5'd0, 5'd0};
        #1;
        vec_cnt++;
        if (rd[31:0] !== 32'h0) begin
            err_cnt++;
            $display("FAIL r0_bypass got %h want 0", rd[31:0]);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rd[31:0] !== 32'h0) begin
            err_cnt++;
            $display("FAIL r0_write got %h want 0", rd[31:0]);
        end
    endtask

    task automatic test_bypass();
        we_n = 1'b1; wa_n = 5'd7; wd_n = 32'h0BAD;
        tick();
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'hA5A5A5A5};
        ra = {5'd7, 5'd0};
        we_n = 1'b1; wa_n = 5'd7; wd_n = 32'hA5A5A5A5;
        ra_n = {5'd7, 5'd0};
        #1;
        vec_cnt++;
        if (rd[63:32] !== 32'hA5A5A5A5) begin
            err_cnt++;
            $display("FAIL bypass_rd1 got %h want a5a5a5a5", rd[63:32]);
        end
        vec_cnt++;
        if (rd_n[63:32] !== 32'h00000BAD) begin
            err_cnt++;
            $display("FAIL nobypass_old got %h want 00000bad", rd_n[63:32]);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rd_n[63:32] !== 32'hA5A5A5A5) begin
            err_cnt++;
            $display("FAIL nobypass_new got %h want a5a5a5a5", rd_n[63:32]);
        end
    endtask

    task automatic test_conflict();
        we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'h22, 32'h11};
        ra = {5'd0, 5'd3};
        #1;
        vec_cnt++;
        if (rd[31:0] !== 32'h22) begin
            err_cnt++;
            $display("FAIL bypass_prio got %h want 00000022", rd[31:0]);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rd[31:0] !== 32'h22 || wr_conflict !== 1'b1) begin
            err_cnt++;
            $display("FAIL conflict_r3 rd=%h conf=%b want 00000022/1", rd[31:0], wr_conflict);
        end
        we = 2'b11; wa = {5'd3, 5'd4}; wd = {32'h33, 32'h44};
        tick();
        idle();
        vec_cnt++;
        if (wr_conflict !== 1'b0) begin
            err_cnt++;
            $display("FAIL conflict_clear got %b want 0", wr_conflict);
        end
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h55, 32'h66};
        tick();
        idle();
        vec_cnt++;
        if (wr_conflict !== 1'b1) begin
            err_cnt++;
            $display("FAIL conflict_r0 got %b want 1", wr_conflict);
        end
        tick();
        vec_cnt++;
        if (wr_conflict !== 1'b0 || wrc_n !== 1'b0) begin
            err_cnt++;
            $display("FAIL conflict_one_cycle got %b/%b want 0/0", wr_conflict, wrc_n);
        end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        ra = {5'd0, 5'd9};
        #1;
        vec_cnt++;
        if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
            err_cnt++;
            $display("FAIL issue_r9 busy=%b pend=%0d want 1/1", rd_busy[0], pend_cnt);
        end
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h99};
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        vec_cnt++;
        if (rd_busy[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL busy_bypass_mask got %b want 0", rd_busy[0]);
        end
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
            err_cnt++;
            $display("FAIL reissue busy=%b pend=%0d want 1/1", rd_busy[0], pend_cnt);
        end
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h98};
        tick();
        idle();
        #1;
        vec_cnt++;
        if (rd_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL writeback busy=%b pend=%0d want 0/0", rd_busy[0], pend_cnt);
        end
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        vec_cnt++;
        if (pend_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL issue_r0 pend=%0d want 0", pend_cnt);
        end
        iss_en_n = 1'b1; iss_addr_n = 5'd9;
        tick();
        idle();
        we_n = 1'b1; wa_n = 5'd9; wd_n = 32'h9;
        ra_n = {5'd0, 5'd9};
        #1;
        vec_cnt++;
        if (busy_n[0] !== 1'b1 || pcnt_n !== 6'd1) begin
            err_cnt++;
            $display("FAIL nb_busy busy=%b pend=%0d want 1/1", busy_n[0], pcnt_n);
        end
        tick();
        idle();
        vec_cnt++;
        if (busy_n[0] !== 1'b0 || pcnt_n !== 6'd0) begin
            err_cnt++;
            $display("FAIL nb_writeback busy=%b pend=%0d want 0/0", busy_n[0], pcnt_n);
        end
    endtask

    task automatic test_reset_mid();
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        iss_addr = 5'd6;
        tick();
        idle();
        vec_cnt++;
        if (pend_cnt !== 6'd2) begin
            err_cnt++;
            $display("FAIL pend_two got %0d want 2", pend_cnt);
        end
        we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h777};
        ra = {5'd6, 5'd4};
        #1;
        vec_cnt++;
        if (rd[31:0] !== 32'h777 || rd_busy !== 2'b10) begin
            err_cnt++;
            $display("FAIL pre_reset rd=%h busy=%b want 00000777/10", rd[31:0], rd_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (rd !== 64'h0 || rd_busy !== 2'b00 || pend_cnt !== 6'd0) begin
            err_cnt++;
            $display("FAIL async_reset rd=%h busy=%b pend=%0d want 0", rd, rd_busy, pend_cnt);
        end
        tick();
        rst_n = 1'b1;
        idle();
        ra = {5'd5, 5'd4};
        #1;
        vec_cnt++;
        if (rd !== 64'h0 || rd_busy !== 2'b00) begin
            err_cnt++;
            $display("FAIL post_reset rd=%h busy=%b want 0/00", rd, rd_busy);
        end
        tick();
        vec_cnt++;
        if (pend_cnt !== 6'd0 || rd[31:0] !== 32'h0) begin
            err_cnt++;
            $display("FAIL post_reset_regs pend=%0d rd=%h want 0/0", pend_cnt, rd[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
